// File: rtl/usb_depacketizer_pkg.sv
// Shared constants and types for the USB stream packetizer/depacketizer pair.
// The packetizer imports the same marker and packet-length defaults, so both ends
// always agree on framing.
package usb_depacketizer_pkg;

    // Receive framing state.
    typedef enum logic [1:0] {
        StHunt,
        StVerify,
        StLocked
    } state_e;

    // Low byte carried by every trailer word.
    localparam logic [7:0] MarkerDefault = 8'hA0;

    // Words per packet, trailer included.
    localparam int unsigned PktWordsDefault = 256;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the depacketizer error statistics.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset, clears the count
//   inc   - increment request, ignored once the count is all ones
//   count - current count
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/usb_depacketizer.sv
// Receive-side USB stream depacketizer. Finds packet framing in a 16-bit
// ready/valid word stream, strips the {seq, marker} trailer of every packet,
// forwards payload words with zero latency and checks marker/sequence continuity.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   s_data_i/valid/rdy - upstream word stream (from the USB FIFO)
//   m_data/valid/last  - payload stream to the sample consumer, m_ready_i backpressure
//   locked_o           - framing locked
//   seq_o              - sequence number of the last accepted valid trailer
//   seq_err_o          - pulse: good marker, unexpected sequence number
//   mark_err_o         - pulse: bad marker while locked, lock lost
//   seq_err_cnt_o      - saturating count of seq_err_o pulses
//   lock_loss_cnt_o    - saturating count of mark_err_o pulses
// PKT_WORDS must be at least 3.
module usb_depacketizer
    import usb_depacketizer_pkg::*;
#(
    parameter int unsigned PKT_WORDS = PktWordsDefault,
    parameter logic [7:0]  MARKER    = MarkerDefault,
    parameter int unsigned ERR_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [15:0]      m_data_o,
    output logic             m_valid_o,
    output logic             m_last_o,
    input  logic             m_ready_i,
    output logic             locked_o,
    output logic [7:0]       seq_o,
    output logic             seq_err_o,
    output logic             mark_err_o,
    output logic [ERR_W-1:0] seq_err_cnt_o,
    output logic [ERR_W-1:0] lock_loss_cnt_o
);

    localparam int unsigned    PosW    = $clog2(PKT_WORDS);
    localparam logic [PosW-1:0] PosLast = PosW'(PKT_WORDS - 1);
    localparam logic [PosW-1:0] PosPen  = PosW'(PKT_WORDS - 2);

    state_e          state_q, state_d;
    logic [PosW-1:0] pos_q, pos_d;
    logic [7:0]      cand_q, cand_d;
    logic [7:0]      seq_q, seq_d;
    logic            seq_err_q, seq_err_d;
    logic            mark_err_q, mark_err_d;

    logic       at_trailer;
    logic       payload_slot;
    logic       accept;
    logic [7:0] word_lo;
    logic [7:0] word_hi;
    logic       marker_ok;

    assign at_trailer   = (pos_q == PosLast);
    assign payload_slot = (state_q == StLocked) && !at_trailer;
    assign word_lo      = s_data_i[7:0];
    assign word_hi      = s_data_i[15:8];
    assign marker_ok    = (word_lo == MARKER);

    // Trailers are always consumed, even under downstream backpressure.
    assign s_ready_o = payload_slot ? m_ready_i : 1'b1;
    assign m_valid_o = payload_slot && s_valid_i;
    assign m_last_o  = (state_q == StLocked) && (pos_q == PosPen);
    assign m_data_o  = s_data_i;
    assign accept    = s_valid_i && s_ready_o;

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        cand_d     = cand_q;
        seq_d      = seq_q;
        seq_err_d  = 1'b0;
        mark_err_d = 1'b0;

        if (accept) begin
            unique case (state_q)
                StHunt: begin
                    if (marker_ok) begin
                        cand_d  = word_hi;
                        pos_d   = '0;
                        state_d = StVerify;
                    end
                end
                StVerify: begin
                    if (!at_trailer) begin
                        pos_d = pos_q + 1'b1;
                    end else if (!marker_ok) begin
                        pos_d   = '0;
                        state_d = StHunt;
                    end else if (word_hi == cand_q + 8'd1) begin
                        seq_d   = word_hi;
                        pos_d   = '0;
                        state_d = StLocked;
                    end else begin
                        // Spacing held but sequence broken: restart verification here.
                        cand_d = word_hi;
                        pos_d  = '0;
                    end
                end
                StLocked: begin
                    if (!at_trailer) begin
                        pos_d = pos_q + 1'b1;
                    end else if (marker_ok) begin
                        seq_err_d = (word_hi != seq_q + 8'd1);
                        seq_d     = word_hi;
                        pos_d     = '0;
                    end else begin
                        // The corrupt word is dropped, not reconsidered as a candidate.
                        mark_err_d = 1'b1;
                        pos_d      = '0;
                        state_d    = StHunt;
                    end
                end
                default: begin
                    pos_d   = '0;
                    state_d = StHunt;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StHunt;
            pos_q      <= '0;
            cand_q     <= '0;
            seq_q      <= '0;
            seq_err_q  <= 1'b0;
            mark_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            cand_q     <= cand_d;
            seq_q      <= seq_d;
            seq_err_q  <= seq_err_d;
            mark_err_q <= mark_err_d;
        end
    end

    assign locked_o   = (state_q == StLocked);
    assign seq_o      = seq_q;
    assign seq_err_o  = seq_err_q;
    assign mark_err_o = mark_err_q;

    sat_counter #(
        .WIDTH(ERR_W)
    ) u_seq_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (seq_err_q),
        .count(seq_err_cnt_o)
    );

    sat_counter #(
        .WIDTH(ERR_W)
    ) u_lock_loss_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (mark_err_q),
        .count(lock_loss_cnt_o)
    );

endmodule

// File: tb/tb_usb_depacketizer.sv
module tb_usb_depacketizer;

    localparam int unsigned P  = 16;
    localparam int unsigned EW = 4;
    localparam logic [7:0]  M  = 8'hA0;
    localparam int          CMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   s_data_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [15:0]   m_data_o;
    logic          m_valid_o;
    logic          m_last_o;
    logic          m_ready_i;
    logic          locked_o;
    logic [7:0]    seq_o;
    logic          seq_err_o;
    logic          mark_err_o;
    logic [EW-1:0] seq_err_cnt_o;
    logic [EW-1:0] lock_loss_cnt_o;

    usb_depacketizer #(
        .PKT_WORDS(P),
        .MARKER   (M),
        .ERR_W    (EW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_data_i       (s_data_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .m_data_o       (m_data_o),
        .m_valid_o      (m_valid_o),
        .m_last_o       (m_last_o),
        .m_ready_i      (m_ready_i),
        .locked_o       (locked_o),
        .seq_o          (seq_o),
        .seq_err_o      (seq_err_o),
        .mark_err_o     (mark_err_o),
        .seq_err_cnt_o  (seq_err_cnt_o),
        .lock_loss_cnt_o(lock_loss_cnt_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 = hunting, 1 = verifying, 2 = locked.
    int         md;
    int         mpos;
    logic [7:0] mcand;
    logic [7:0] mseq;
    bit         mse;
    bit         mme;
    int         mcs;
    int         mcl;

    function automatic void model_reset();
        md = 0; mpos = 0; mcand = 8'h00; mseq = 8'h00;
        mse = 0; mme = 0; mcs = 0; mcl = 0;
    endfunction

    function automatic void model_word(input logic [15:0] w);
        logic [7:0] hi;
        bit         mk;
        hi = w[15:8];
        mk = (w[7:0] == M);
        if (md == 0) begin
            if (mk) begin
                mcand = hi; mpos = 0; md = 1;
            end
        end else if (mpos != P - 1) begin
            mpos = mpos + 1;
        end else if (!mk) begin
            if (md == 2) mme = 1;
            md = 0; mpos = 0;
        end else if (md == 1) begin
            if (hi == 8'(mcand + 1)) begin
                mseq = hi; md = 2;
            end else begin
                mcand = hi;
            end
            mpos = 0;
        end else begin
            if (hi != 8'(mseq + 1)) mse = 1;
            mseq = hi; mpos = 0;
        end
    endfunction

    int fwd_cnt = 0;

    // One clock: drive at the falling edge, check #1 later, then advance the model.
    task automatic cycle(input logic v, input logic [15:0] d, input logic mr, output bit acc);
        bit pay;
        bit erdy;
        bit evalid;
        s_valid_i = v; s_data_i = d; m_ready_i = mr;
        #1;
        pay    = (md == 2) && (mpos < P - 1);
        erdy   = pay ? mr : 1'b1;
        evalid = pay && v;
        check("s_ready", 32'(s_ready_o), 32'(erdy));
        check("m_valid", 32'(m_valid_o), 32'(evalid));
        check("m_last", 32'(m_last_o), 32'((md == 2) && (mpos == P - 2)));
        check("locked", 32'(locked_o), 32'(md == 2));
        check("seq", 32'(seq_o), 32'(mseq));
        check("seq_err", 32'(seq_err_o), 32'(mse));
        check("mark_err", 32'(mark_err_o), 32'(mme));
        check("seq_err_cnt", 32'(seq_err_cnt_o), 32'(mcs));
        check("lock_loss_cnt", 32'(lock_loss_cnt_o), 32'(mcl));
        if (evalid) check("m_data", 32'(m_data_o), 32'(d));
        if (m_valid_o && m_ready_i) fwd_cnt++;
        acc = v && erdy;
        if (rst) begin
            model_reset();
        end else begin
            if (mse && mcs < CMAX) mcs++;
            if (mme && mcl < CMAX) mcl++;
            mse = 0; mme = 0;
            if (acc) model_word(d);
        end
        @(negedge clk);
    endtask

    // Packetizer model.
    int         tx_pos;
    logic [7:0] tx_seq;
    logic [15:0] ramp;
    int gap_pct = 0;
    int rdy_pct = 100;

    task automatic send_word(input logic [15:0] w);
        bit acc;
        int tries;
        for (int g = 0; g < 3; g++) begin
            if (int'($urandom_range(99)) >= gap_pct) break;
            cycle(1'b0, 16'($urandom), 1'($urandom_range(1)), acc);
        end
        tries = 0;
        acc   = 0;
        while (!acc && tries < 100) begin
            cycle(1'b1, w, (int'($urandom_range(99)) < rdy_pct), acc);
            tries++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_words(input int n);
        for (int i = 0; i < n; i++) begin
            if (tx_pos == P - 1) begin
                send_word({tx_seq, M});
                tx_pos = 0;
                tx_seq = tx_seq + 8'd1;
            end else begin
                send_word(ramp);
                ramp   = ramp + 16'd1;
                tx_pos = tx_pos + 1;
            end
        end
    endtask

    task automatic send_until_trailer();
        send_words(P - 1 - tx_pos);
    endtask

    task automatic tx_restart(input int pos, input logic [7:0] sq, input logic [15:0] r);
        tx_pos = pos; tx_seq = sq; ramp = r;
    endtask

    initial begin
        bit acc;
        s_valid_i = 1'b0; s_data_i = 16'h0; m_ready_i = 1'b1; rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check("rst_locked", 32'(locked_o), 32'd0);
        check("rst_ready", 32'(s_ready_o), 32'd1);
        check("rst_seq", 32'(seq_o), 32'd0);
        check("rst_cnt", 32'(seq_err_cnt_o), 32'd0);
        rst = 1'b0;

        // Loopback from reset.
        tx_restart(0, 8'h00, 16'h0000);
        send_words(2 * P);
        check("lb_locked", 32'(locked_o), 32'd1);
        check("lb_seq", 32'(seq_o), 32'h01);
        send_words(2 * P);
        check("lb_seq3", 32'(seq_o), 32'h03);
        check("lb_no_err", 32'(seq_err_cnt_o), 32'd0);

        // Stream joined mid-packet.
        rst = 1'b1;
        cycle(1'b0, 16'h0, 1'b1, acc);
        rst = 1'b0;
        tx_restart(5, 8'h10, 16'h0300);
        send_words((P - 5) + 2 * P);
        check("mid_locked", 32'(locked_o), 32'd1);
        check("mid_seq", 32'(seq_o), 32'h12);

        // Sequence jump while locked.
        send_until_trailer();
        tx_seq = tx_seq + 8'd4;
        send_words(1);
        check("seqj_pulse", 32'(seq_err_o), 32'd1);
        check("seqj_seq", 32'(seq_o), 32'h17);
        send_words(P);
        check("seqj_cnt", 32'(seq_err_cnt_o), 32'd1);
        check("seqj_locked", 32'(locked_o), 32'd1);

        // Corrupt marker while locked.
        send_until_trailer();
        send_word({tx_seq, 8'h00});
        tx_pos = 0;
        tx_seq = tx_seq + 8'd1;
        check("mark_pulse", 32'(mark_err_o), 32'd1);
        check("mark_unlocked", 32'(locked_o), 32'd0);
        send_words(2 * P);
        check("mark_cnt", 32'(lock_loss_cnt_o), 32'd1);
        check("mark_relock", 32'(locked_o), 32'd1);

        // Random gaps and downstream backpressure.
        gap_pct = 30; rdy_pct = 50; fwd_cnt = 0;
        send_words(20 * P);
        check("rnd_fwd", 32'(fwd_cnt), 32'(20 * (P - 1)));
        check("rnd_locked", 32'(locked_o), 32'd1);
        gap_pct = 0; rdy_pct = 100;

        // Reset mid-packet while locked.
        send_words(P / 2);
        rst = 1'b1;
        cycle(1'b1, 16'h1234, 1'b1, acc);
        rst = 1'b0;
        check("rstm_locked", 32'(locked_o), 32'd0);
        check("rstm_seq", 32'(seq_o), 32'd0);
        check("rstm_lcnt", 32'(lock_loss_cnt_o), 32'd0);
        check("rstm_valid", 32'(m_valid_o), 32'd0);
        tx_restart(0, 8'h40, 16'h0000);
        send_words(2 * P);
        check("rstm_relock", 32'(locked_o), 32'd1);

        // Saturate the sequence error counter.
        for (int k = 0; k < CMAX + 3; k++) begin
            send_until_trailer();
            tx_seq = tx_seq + 8'd1;
            send_words(1);
        end
        check("sat_cnt", 32'(seq_err_cnt_o), 32'(CMAX));

        // Sequence wrap FF -> 00 is continuous.
        send_until_trailer();
        tx_seq = 8'hFF;
        send_words(1);
        send_words(P);
        check("wrap_seq", 32'(seq_o), 32'h00);
        check("wrap_no_pulse", 32'(seq_err_o), 32'd0);
        check("wrap_locked", 32'(locked_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/usb_depacketizer.md
# usb_depacketizer

Receive-side counterpart of the USB stream packetizer. Consumes a 16-bit ready/valid word stream framed as PKT_WORDS-word packets: PKT_WORDS-1 payload words, then one trailer word {seq[7:0], MARKER}. Acquires frame lock, strips trailers, forwards payload with a packet-end flag, and checks trailer marker and sequence continuity. Sits between the USB FIFO read side and the sample consumer.

## Interface
- PKT_WORDS, 256, total words per packet including trailer; must be ≥3.
- MARKER, 8'hA0, required low byte of every trailer.
- ERR_W, 16, width of the saturating error counters.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_data_i  in  16  input word.
- s_valid_i  in  1  input word valid.
- s_ready_o  out  1  input word accepted when s_valid_i & s_ready_o.
- m_data_o  out  16  payload word; equals s_data_i.
- m_valid_o  out  1  payload word valid.
- m_last_o  out  1  qualifies the last payload word of a packet.
- m_ready_i  in  1  downstream ready.
- locked_o  out  1  high in LOCKED state.
- seq_o  out  8  seq field of the most recently accepted valid trailer.
- seq_err_o  out  1  one-cycle pulse: trailer marker OK, seq ≠ expected.
- mark_err_o  out  1  one-cycle pulse: trailer marker mismatch while LOCKED (lock lost).
- seq_err_cnt_o  out  ERR_W  saturating count of seq_err_o pulses.
- lock_loss_cnt_o  out  ERR_W  saturating count of mark_err_o pulses.

## Operation
- Accept: s_valid_i & s_ready_o. Only accepted words change state.
- pos counter, width $clog2(PKT_WORDS), counts words in current packet; wraps to 0 after the trailer.
- States:
  - HUNT: s_ready_o=1, m_valid_o=0. Each accepted word with low byte == MARKER: cand ← high byte, pos ← 0, go VERIFY.
  - VERIFY: s_ready_o=1, m_valid_o=0. Discard words until pos == PKT_WORDS-1. At that word: marker OK and high byte == cand+1 (mod 256) → seq_o ← high byte, pos ← 0, go LOCKED. Marker OK, wrong seq → cand ← high byte, pos ← 0, stay VERIFY. Marker bad → HUNT.
  - LOCKED, pos < PKT_WORDS-1 (payload): s_ready_o = m_ready_i; m_valid_o = s_valid_i; m_last_o = (pos == PKT_WORDS-2).
  - LOCKED, pos == PKT_WORDS-1 (trailer): s_ready_o=1 regardless of m_ready_i; m_valid_o=0. Marker OK, seq == seq_o+1 → seq_o update, stay. Marker OK, seq mismatch → seq_err_o pulse, seq_o ← received seq (resynchronise), stay. Marker bad → mark_err_o pulse, go HUNT; the bad word is not re-evaluated as a candidate.
- Error counters increment on their pulses and saturate at 2^ERR_W-1.
- m_data_o = s_data_i at all times; consumers qualify it with m_valid_o.

## Timing
- Reset values: state HUNT, pos 0, seq_o 0, both counters 0, locked_o/seq_err_o/mark_err_o 0, m_valid_o 0, m_last_o 0, s_ready_o 1.
- Payload path is combinational: zero latency; s_ready_o depends combinationally on m_ready_i only in LOCKED payload positions.
- Error pulses and locked_o are registered and assert the cycle after the trailer is accepted.
- Lock acquisition: locked_o rises the cycle after the second consecutive correctly spaced, correctly sequenced trailer.
- Stalls (s_valid_i=0 or m_ready_i=0) freeze pos and state.
- rst mid-packet: all state returns to reset values next cycle; in-flight packet is discarded, relock required.
- seq wrap 8'hFF → 8'h00 is a valid continuation.

## Structure
- Shared package: state enum (HUNT, VERIFY, LOCKED), default MARKER constant 8'hA0, default PKT_WORDS 256. The packetizer imports the same constants.
- Saturating error counter is a natural sub-module: sat_counter (params WIDTH; ports clk, rst, inc, count).
- Single module otherwise; no internal buffering.

## Test plan
- Packetizer→depacketizer loopback from reset, payload ramp 0,1,2…, m_ready_i always 1 → first two packets discarded, locked_o high after trailer {8'h01,8'hA0}, payload from packet 2 onward matches ramp, m_last_o on every 255th payload word, zero errors.
- Start stream at word 100 of a packet → HUNT, VERIFY, lock after two trailers; no spurious outputs before locked_o.
- While locked, replace trailer seq 8'h05 with 8'h09 → one seq_err_o pulse, seq_err_cnt_o=1, locked_o stays 1; next trailer 8'h0A accepted silently.
- While locked, corrupt trailer to 8'h05_00 → mark_err_o pulse, lock_loss_cnt_o=1, locked_o drops, relock after two good trailers.
- Random m_ready_i (50%) and s_valid_i gaps → no payload word lost or duplicated; trailers still consumed while m_ready_i=0.
- Assert rst at payload word 128 while locked → next cycle all outputs at reset values, then relock; seq_err_cnt_o stuck at 2^ERR_W-1 after forcing 70 000 seq errors with ERR_W=16.
